modu_neg_counter: RTL and testbench

- Frame-based statistics block in the signal-processing path. Requests a frame of K signed N-bit samples from an upstream source and counts the negative ones.
- Publishes the running count on out_data and raises stop when the frame is complete.
- The upstream source drives in_data/ready; downstream logic reads out_data once stop is high.

---
 rtl/modu_neg_counter.sv | 74 +++++++
 tb/tb_modu_neg_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/modu_neg_counter.sv
// Frame statistics: requests K signed samples from upstream and counts the negative ones.
// out_data carries the running count and is final once stop is high.
//
// state   | meaning
// IDLE    | out of reset, outputs cleared, moves to COLLECT on next edge
// COLLECT | send_data high, each ready-qualified sample is counted
// DONE    | frame complete, stop high, count frozen until reset
module modu_neg_counter #(
    parameter int N = 8,
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ready,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] out_data,
    output logic         send_data,
    output logic         stop
);

    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] sample_cnt;
    logic [N-1:0]  neg_next;

    // The sign bit alone classifies a sample; zero is non-negative.
    assign neg_next = out_data + N'(in_data[N-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_data   <= '0;
            send_data  <= 1'b0;
            stop       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= COLLECT;
                    send_data <= 1'b1;
                end
                COLLECT: begin
                    if (ready) begin
                        sample_cnt <= sample_cnt + CW'(1);
                        out_data   <= neg_next;
                        if (sample_cnt == LAST_IDX) begin
                            state     <= DONE;
                            stop      <= 1'b1;
                            send_data <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    stop      <= 1'b1;
                    send_data <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    send_data <= 1'b0;
                    stop      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modu_neg_counter.sv
// Directed bench for modu_neg_counter: hand-built frames with known negative counts.
module tb_modu_neg_counter;

    logic       clk;
    logic       rst;
    logic       ready;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       send_data;
    logic       stop;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt;
    logic signed [7:0] samples [16];

    modu_neg_counter #(.N(8), .K(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .send_data (send_data),
        .stop      (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ready   = 1'b0;
        in_data = 8'd0;
        #3;
        check("rst_out_data", 32'(out_data), 0);
        check("rst_send", 32'(send_data), 0);
        check("rst_stop", 32'(stop), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_exit_send", 32'(send_data), 1);
        check("idle_exit_stop", 32'(stop), 0);
        exp_cnt = 0;
    endtask

    // Accept n samples from the table; with toggle, an idle cycle carrying a
    // positive value precedes each accepted one.
    task automatic run_frame(input string tag, input int n, input bit toggle, input bit expect_done);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                ready   = 1'b0;
                in_data = 8'd55;
                @(posedge clk); #1;
                check({tag, "_hold"}, 32'(out_data), 32'(exp_cnt));
            end
            ready   = 1'b1;
            in_data = samples[i];
            @(posedge clk); #1;
            if (samples[i] < 0) exp_cnt++;
            check({tag, "_cnt"}, 32'(out_data), 32'(exp_cnt));
            if (expect_done && i == n - 1) begin
                check({tag, "_stop"}, 32'(stop), 1);
                check({tag, "_send"}, 32'(send_data), 0);
            end else begin
                check({tag, "_stop"}, 32'(stop), 0);
                check({tag, "_send"}, 32'(send_data), 1);
            end
        end
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; in_data = 8'd0;

        // Frame 1: five negatives including -128; zero and 127 non-negative.
        do_reset();
        samples = '{-8'sd1, 8'sd0, 8'sd5, -8'sd128, 8'sd127, 8'sd3, -8'sd3, 8'sd0,
                    8'sd10, -8'sd7, 8'sd1, 8'sd2, 8'sd100, -8'sd50, 8'sd0, 8'sd127};
        run_frame("f1", 16, 1'b0, 1'b1);
        check("f1_final", 32'(out_data), 5);
        @(posedge clk); #1;
        check("f1_held", 32'(out_data), 5);

        // Frame 2: ready toggling, all negative accepted samples.
        do_reset();
        for (int i = 0; i < 16; i++) samples[i] = 8'(-(i + 1));
        run_frame("f2", 16, 1'b1, 1'b1);
        check("f2_final", 32'(out_data), 16);

        // Frame 3: zero/positive only.
        do_reset();
        for (int i = 0; i < 16; i++) samples[i] = (i % 3 == 0) ? 8'sd0 : ((i % 3 == 1) ? 8'sd1 : 8'sd127);
        run_frame("f3", 16, 1'b0, 1'b1);
        check("f3_final", 32'(out_data), 0);

        // Frame 4: -128 / 0 alternating, then samples offered while DONE.
        do_reset();
        for (int i = 0; i < 16; i++) samples[i] = (i % 2 == 0) ? -8'sd128 : 8'sd0;
        run_frame("f4", 16, 1'b0, 1'b1);
        check("f4_final", 32'(out_data), 8);
        ready   = 1'b1;
        in_data = 8'hFB;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("done_out", 32'(out_data), 8);
            check("done_stop", 32'(stop), 1);
            check("done_send", 32'(send_data), 0);
        end
        ready = 1'b0;

        // Frame 5: async reset after 7 samples (3 negative), then a fresh frame.
        do_reset();
        samples = '{-8'sd1, 8'sd2, -8'sd2, 8'sd3, -8'sd3, 8'sd4, 8'sd5, 8'sd0,
                    8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_frame("f5a", 7, 1'b0, 1'b0);
        check("f5a_partial", 32'(out_data), 3);
        rst = 1'b1;
        #1;
        check("async_out", 32'(out_data), 0);
        check("async_send", 32'(send_data), 0);
        check("async_stop", 32'(stop), 0);
        do_reset();
        for (int i = 0; i < 16; i++) samples[i] = 8'(i);
        samples[4]  = -8'sd9;
        samples[11] = -8'sd100;
        run_frame("f5b", 16, 1'b0, 1'b1);
        check("f5b_final", 32'(out_data), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
